intr_ctrl: RTL and testbench

Eight-input priority interrupt controller that sits between the external `interrupts` lines and the MIPS core's exception logic. It synchronises and captures the requests, applies a software mask and edge/level selection, and drives a single request/vector/acknowledge handshake to the core. In-service tracking allows higher-priority sources to nest. Configuration and EOI are written over the core's data-memory write bus (`memwrite`/`dataadr`/`writedata`).

---
 rtl/intr_ctrl.sv | 163 ++++++++++++++++
 tb/tb_intr_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Eight-input priority interrupt controller with request/vector/ack handshake,
// edge/level capture, software mask and nested in-service tracking.
module intr_ctrl #(
    parameter int unsigned NIRQ    = 8,
    parameter logic [31:0] BASEADR = 32'hFFFF_FF00
) (
    input  logic            ph1,
    input  logic            reset,
    input  logic [NIRQ-1:0] interrupts,
    input  logic            memwrite,
    input  logic [31:0]     dataadr,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            irqreq,
    output logic [2:0]      irqvec,
    input  logic            irqack
);

    typedef enum logic [1:0] {StIdle, StReq, StAckd} state_e;

    localparam logic [2:0] OffMask  = 3'd0;
    localparam logic [2:0] OffPend  = 3'd1;
    localparam logic [2:0] OffInsrv = 3'd2;
    localparam logic [2:0] OffEoi   = 3'd3;
    localparam logic [2:0] OffEdge  = 3'd4;

    state_e state_q, state_d;

    logic [NIRQ-1:0] sync1_q, s2_q, s3_q;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] insrv_q, insrv_d;
    logic [NIRQ-1:0] edge_q, edge_d;
    logic [2:0]      vec_q, vec_d;

    logic            win_sel, wr_en;
    logic [2:0]      off;
    logic [NIRQ-1:0] wdata;
    logic [NIRQ-1:0] insrv_low, allowed, cand;
    logic [NIRQ-1:0] w1c, ack_bit, rise;
    logic            eoi, ack_ev, win_valid, vec_is_cand;
    logic [2:0]      win_idx;
    logic            unused_bits;

    assign unused_bits = ^{writedata[31:NIRQ], dataadr[1:0]};

    // Bus decode
    assign win_sel = (dataadr[31:5] == BASEADR[31:5]);
    assign wr_en   = memwrite & win_sel;
    assign off     = dataadr[4:2];
    assign wdata   = writedata[NIRQ-1:0];
    assign eoi     = wr_en && (off == OffEoi);
    assign w1c     = (wr_en && (off == OffPend)) ? wdata : '0;

    // Only sources strictly more urgent than the most urgent in-service one may compete.
    assign insrv_low = insrv_q & (~insrv_q + 1'b1);
    assign allowed   = (insrv_q == '0) ? '1 : (insrv_low - 1'b1);
    assign cand      = pend_q & mask_q & allowed;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_valid = 1'b1;
                win_idx   = i[2:0];
            end
        end
    end

    assign vec_is_cand = cand[vec_q];
    assign ack_ev      = (state_q == StReq) && irqack;
    assign ack_bit     = ack_ev ? ({{(NIRQ-1){1'b0}}, 1'b1} << vec_q) : '0;
    assign rise        = s2_q & ~s3_q;

    // Register next-state: edge capture beats W1C/ack; ack set beats EOI clear.
    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        pend_d  = (edge_q & ((pend_q & ~w1c & ~ack_bit) | rise)) | (~edge_q & s2_q);
        insrv_d = (eoi ? (insrv_q & ~insrv_low) : insrv_q) | ack_bit;
        if (wr_en && (off == OffMask)) begin
            mask_d = wdata;
        end
        if (wr_en && (off == OffEdge)) begin
            edge_d = wdata;
        end
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            insrv_q <= '0;
            edge_q  <= '1;
            vec_q   <= '0;
        end else begin
            sync1_q <= interrupts;
            s2_q    <= sync1_q;
            s3_q    <= s2_q;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            insrv_q <= insrv_d;
            edge_q  <= edge_d;
            vec_q   <= vec_d;
        end
    end

    // FSM state register
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the vector is latched only when leaving IDLE so it stays stable in REQ.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d = StReq;
                    vec_d   = win_idx;
                end
            end
            StReq: begin
                if (irqack) begin
                    state_d = StAckd;
                end else if (!vec_is_cand) begin
                    state_d = StIdle;
                end
            end
            StAckd:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        irqreq = (state_q == StReq);
        irqvec = vec_q;
    end

    always_comb begin
        readdata = '0;
        if (win_sel) begin
            unique case (off)
                OffMask:  readdata = {{(32-NIRQ){1'b0}}, mask_q};
                OffPend:  readdata = {{(32-NIRQ){1'b0}}, pend_q};
                OffInsrv: readdata = {{(32-NIRQ){1'b0}}, insrv_q};
                OffEdge:  readdata = {{(32-NIRQ){1'b0}}, edge_q};
                default:  readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed scenarios with literal expectations plus randomized
// traffic compared every cycle against a per-source behavioural model.
module tb_intr_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] WMASK = 32'hFFFF_FFE0;

    logic        ph1 = 1'b0;
    logic        reset;
    logic [7:0]  interrupts;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irqreq;
    logic [2:0]  irqvec;
    logic        irqack;

    int n_tests = 0;
    int n_fail  = 0;

    intr_ctrl dut (
        .ph1        (ph1),
        .reset      (reset),
        .interrupts (interrupts),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .readdata   (readdata),
        .irqreq     (irqreq),
        .irqvec     (irqvec),
        .irqack     (irqack)
    );

    always #5 ph1 = ~ph1;

    // Behavioural model state; m_st: 0 idle, 1 requesting, 2 one-cycle gap after ack
    logic [7:0] m_mask, m_pend, m_insrv, m_edge, m_s1, m_s2, m_s3;
    int         m_st, m_vec;

    function automatic logic [31:0] mread(input logic [31:0] adr);
        logic [31:0] r;
        r = 32'h0;
        if ((adr & WMASK) == BASE) begin
            case (int'(adr[4:2]))
                0: r = {24'h0, m_mask};
                1: r = {24'h0, m_pend};
                2: r = {24'h0, m_insrv};
                4: r = {24'h0, m_edge};
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    always @(posedge ph1 or posedge reset) begin : model
        int li, win, off;
        logic wr, ackev, vec_ok;
        logic [7:0] np, ni, wd;
        if (reset) begin
            m_mask = 8'h00; m_pend = 8'h00; m_insrv = 8'h00; m_edge = 8'hFF;
            m_s1 = 8'h00; m_s2 = 8'h00; m_s3 = 8'h00; m_st = 0; m_vec = 0;
        end else begin
            li = 8;
            for (int i = 7; i >= 0; i--) if (m_insrv[i]) li = i;
            win = -1;
            for (int i = 0; i < 8; i++)
                if (win < 0 && i < li && m_pend[i] && m_mask[i]) win = i;
            wr     = memwrite && ((dataadr & WMASK) == BASE);
            off    = int'(dataadr[4:2]);
            wd     = writedata[7:0];
            ackev  = (m_st == 1) && irqack;
            vec_ok = (m_vec < li) && m_pend[m_vec] && m_mask[m_vec];
            for (int i = 0; i < 8; i++) begin
                if (m_edge[i]) begin
                    np[i] = m_pend[i];
                    if (wr && off == 1 && wd[i]) np[i] = 1'b0;
                    if (ackev && m_vec == i) np[i] = 1'b0;
                    if (m_s2[i] && !m_s3[i]) np[i] = 1'b1;
                end else begin
                    np[i] = m_s2[i];
                end
            end
            ni = m_insrv;
            if (wr && off == 3 && li < 8) ni[li] = 1'b0;
            if (ackev) ni[m_vec] = 1'b1;
            case (m_st)
                0: if (win >= 0) begin m_st = 1; m_vec = win; end
                1: if (ackev) m_st = 2; else if (!vec_ok) m_st = 0;
                default: m_st = 0;
            endcase
            if (wr && off == 0) m_mask = wd;
            if (wr && off == 4) m_edge = wd;
            m_pend = np;
            m_insrv = ni;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = interrupts;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge ph1) begin
        #1;
        if (!reset) begin
            chk("model_irqreq", int'(irqreq), int'(m_st == 1));
            if (m_st == 1) chk("model_irqvec", int'(irqvec), m_vec);
            chk("model_readdata", int'(readdata), int'(mread(dataadr)));
        end
    end

    task automatic tick();
        @(negedge ph1);
    endtask

    task automatic wr(input int off, input logic [7:0] d);
        memwrite  = 1'b1;
        dataadr   = BASE + 32'(off * 4);
        writedata = {24'h0, d};
        tick();
        memwrite  = 1'b0;
        dataadr   = 32'h0;
    endtask

    task automatic rd(input int off, input int exp, input string name);
        dataadr = BASE + 32'(off * 4);
        #1;
        chk(name, int'(readdata), exp);
    endtask

    task automatic pulse(input logic [7:0] bits);
        interrupts = interrupts | bits;
        tick();
        interrupts = interrupts & ~bits;
    endtask

    task automatic wait_req(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (irqreq) begin ok = 1'b1; break; end
            tick();
        end
        chk(name, int'(ok), 1);
    endtask

    task automatic ack();
        irqack = 1'b1;
        tick();
        irqack = 1'b0;
    endtask

    task automatic eoi();
        wr(3, 8'h00);
    endtask

    initial begin
        reset = 1'b1; interrupts = 8'h00; memwrite = 1'b0; dataadr = 32'h0;
        writedata = 32'h0; irqack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("reset_irqreq", int'(irqreq), 0);
        chk("reset_irqvec", int'(irqvec), 0);
        rd(0, 'h00, "reset_mask");
        rd(1, 'h00, "reset_pend");
        rd(2, 'h00, "reset_insrv");
        rd(4, 'hFF, "reset_edge");
        dataadr = 32'h0000_1000;
        #1 chk("outside_window_read", int'(readdata), 0);

        // Basic edge handshake with exact latency
        wr(0, 8'h04);
        interrupts[2] = 1'b1;
        tick();
        interrupts[2] = 1'b0;
        tick(); tick();
        chk("lat_not_yet", int'(irqreq), 0);
        tick();
        chk("lat4_irqreq", int'(irqreq), 1);
        chk("lat4_irqvec", int'(irqvec), 2);
        ack();
        chk("ackd_irqreq", int'(irqreq), 0);
        rd(1, 'h00, "ack_pend");
        rd(2, 'h04, "ack_insrv");
        eoi();
        rd(2, 'h00, "eoi_insrv");

        // Priority and nesting
        wr(0, 8'h2A);
        pulse(8'h28);
        wait_req("prio_req");
        chk("prio_vec3", int'(irqvec), 3);
        ack();
        pulse(8'h02);
        wait_req("nest_req");
        chk("nest_vec1", int'(irqvec), 1);
        rd(2, 'h08, "nest_insrv");
        rd(1, 'h22, "nest_pend");
        ack();
        rd(2, 'h0A, "nest_insrv2");
        eoi();
        rd(2, 'h08, "eoi1_insrv");
        repeat (5) tick();
        chk("blocked_by_3", int'(irqreq), 0);
        eoi();
        wait_req("late_req");
        chk("late_vec5", int'(irqvec), 5);
        ack();
        eoi();

        // Blocking by a more urgent in-service source
        wr(0, 8'h12);
        pulse(8'h02);
        wait_req("blk_req1");
        ack();
        rd(2, 'h02, "blk_insrv");
        pulse(8'h10);
        repeat (8) tick();
        chk("blk_held", int'(irqreq), 0);
        eoi();
        wait_req("blk_req4");
        chk("blk_vec4", int'(irqvec), 4);
        ack();
        eoi();

        // Withdraw by masking
        wr(0, 8'h40);
        pulse(8'h40);
        wait_req("wd_req");
        chk("wd_vec6", int'(irqvec), 6);
        wr(0, 8'h00);
        tick();
        chk("wd_dropped", int'(irqreq), 0);
        rd(1, 'h40, "wd_pend");
        wr(1, 8'h40);
        rd(1, 'h00, "w1c_pend");

        // Level mode
        wr(4, 8'hFE);
        wr(0, 8'h01);
        interrupts[0] = 1'b1;
        wait_req("lvl_req");
        chk("lvl_vec0", int'(irqvec), 0);
        ack();
        rd(2, 'h01, "lvl_insrv");
        eoi();
        wait_req("lvl_rereq");
        interrupts[0] = 1'b0;
        repeat (5) tick();
        chk("lvl_withdraw", int'(irqreq), 0);
        wr(4, 8'hFF);

        // Edge capture and W1C collide on bit 7
        wr(0, 8'h00);
        interrupts[7] = 1'b1;
        tick(); tick();
        wr(1, 8'h80);
        interrupts[7] = 1'b0;
        rd(1, 'h80, "collide_pend");
        wr(1, 8'h80);

        // Reset mid-handshake
        wr(0, 8'h08);
        pulse(8'h08);
        wait_req("rst_req");
        reset = 1'b1;
        #1;
        chk("rst_irqreq", int'(irqreq), 0);
        chk("rst_irqvec", int'(irqvec), 0);
        rd(0, 'h00, "rst_mask");
        rd(4, 'hFF, "rst_edge");
        tick();
        reset = 1'b0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            interrupts = interrupts ^ 8'($urandom & $urandom & $urandom);
            irqack     = ($urandom_range(0, 2) == 0);
            memwrite   = ($urandom_range(0, 5) == 0);
            writedata  = $urandom;
            if ($urandom_range(0, 9) == 0)
                dataadr = $urandom;
            else
                dataadr = BASE | 32'($urandom_range(0, 31));
            if (memwrite && dataadr[4:2] == 3'd4 && $urandom_range(0, 1) == 0)
                writedata[7:0] = 8'hFF;
            reset = ($urandom_range(0, 799) == 0);
            tick();
        end
        reset = 1'b0; memwrite = 1'b0; irqack = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
